// File: rtl/match_ctrl.sv
// Match controller: sensor synchronizer/edge detector, goal pulse, PLAY/LOCKOUT/OVER FSM.
// Optional match timer enabled by defining MATCH_TIMER_EN.
module match_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int LOCKOUT_TICKS = 50000000,
  parameter int MATCH_SECS    = 90,
  parameter int WIN_SCORE     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sensor,
  input  logic [3:0] score0,
  input  logic [3:0] score1,
  output logic       goal,
  output logic       dis_score,
  output logic [1:0] state,
  output logic [6:0] time_left,
  output logic       match_over
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAY    = 2'b01,
    LOCKOUT = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam int LOCK_W = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;

  state_t            state_q, state_d;
  logic              sens_p0, sens_p1, sens_p2;
  logic              rise;
  logic              goal_q, goal_d;
  logic              win;
  logic              expired;
  logic [LOCK_W-1:0] lock_q;

  function automatic logic win_reached(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] total;
    total = 7'(tens) * 7'd10 + 7'(ones);
    return total >= 7'(WIN_SCORE);
  endfunction

  // p0/p1: two-flop synchronizer; p2: previous synchronized level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sens_p0 <= 1'b0;
      sens_p1 <= 1'b0;
      sens_p2 <= 1'b0;
    end else begin
      sens_p0 <= sensor;
      sens_p1 <= sens_p0;
      sens_p2 <= sens_p1;
    end
  end

  assign rise = sens_p1 & ~sens_p2;
  assign win  = win_reached(score1, score0);

`ifdef MATCH_TIMER_EN
  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PRE_W-1:0] presc_q;
  logic [6:0]       time_q;
  logic             wrap;

  assign wrap = (presc_q == PRE_W'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      time_q  <= 7'(MATCH_SECS);
    end else begin
      case (state_q)
        IDLE: time_q <= 7'(MATCH_SECS);
        PLAY, LOCKOUT: begin
          if (wrap) begin
            presc_q <= '0;
            if (time_q != 7'd0) time_q <= time_q - 7'd1;
          end else begin
            presc_q <= presc_q + PRE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign expired   = (time_q == 7'd0);
  assign time_left = time_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TICKS_PER_SEC), 32'(MATCH_SECS)};
  assign expired    = 1'b0;
  assign time_left  = 7'd0;
`endif

  // Win beats expiry beats lockout-done/goal; a goal is still pulsed on the expiry cycle.
  always_comb begin
    state_d = state_q;
    goal_d  = rise && (state_q == PLAY);
    case (state_q)
      IDLE:    if (start) state_d = PLAY;
      PLAY: begin
        if (win)          state_d = OVER;
        else if (expired) state_d = OVER;
        else if (rise)    state_d = LOCKOUT;
      end
      LOCKOUT: begin
        if (win)                  state_d = OVER;
        else if (expired)         state_d = OVER;
        else if (lock_q == '0)    state_d = PLAY;
      end
      OVER:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      goal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      goal_q  <= goal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
    end else if (state_q == PLAY && state_d == LOCKOUT) begin
      lock_q <= LOCK_W'(LOCKOUT_TICKS - 1);
    end else if (state_q == LOCKOUT && lock_q != '0) begin
      lock_q <= lock_q - LOCK_W'(1);
    end
  end

  // Gating with rst keeps a pending goal from reaching the score counter and clears it at once.
  assign goal       = goal_q & ~rst;
  assign dis_score  = (state_q != IDLE) & ~rst;
  assign state      = state_q;
  assign match_over = (state_q == OVER);

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with an attached BCD score counter model.
module tb_match_ctrl;

  localparam int TPS  = 10;
  localparam int LOCK = 5;
  localparam int SECS = 3;
  localparam int WIN  = 3;
`ifdef MATCH_TIMER_EN
  localparam int TL_RST = SECS;
`else
  localparam int TL_RST = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       sensor;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       goal;
  logic       dis_score;
  logic [1:0] state;
  logic [6:0] time_left;
  logic       match_over;

  int n_cmp = 0;
  int n_err = 0;
  int goal_cnt = 0;

  match_ctrl #(
    .TICKS_PER_SEC(TPS),
    .LOCKOUT_TICKS(LOCK),
    .MATCH_SECS(SECS),
    .WIN_SCORE(WIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sensor(sensor),
    .score0(score0),
    .score1(score1),
    .goal(goal),
    .dis_score(dis_score),
    .state(state),
    .time_left(time_left),
    .match_over(match_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BCD score counter: cleared while dis_score is low, increments on goal
  always @(posedge clk) begin
    if (!dis_score) begin
      score0 <= 4'd0;
      score1 <= 4'd0;
    end else if (goal) begin
      if (score0 == 4'd9) begin
        score0 <= 4'd0;
        score1 <= score1 + 4'd1;
      end else begin
        score0 <= score0 + 4'd1;
      end
    end
    if (goal) goal_cnt <= goal_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; sensor = 1'b0;
    score0 = 4'd0; score1 = 4'd0;
    step(2);
    check("rst_state", 32'(state), 32'h0);
    check("rst_goal", 32'(goal), 32'h0);
    check("rst_dis", 32'(dis_score), 32'h0);
    check("rst_over", 32'(match_over), 32'h0);
    check("rst_time", 32'(time_left), 32'(TL_RST));
    rst = 1'b0;
    step(1);

    // match 1: three goals to a win
    start = 1'b1; step(1); start = 1'b0;
    check("play_state", 32'(state), 32'h1);
    check("play_dis", 32'(dis_score), 32'h1);
    sensor = 1'b1; step(1); sensor = 1'b0;
    step(1);
    check("goal1_early", 32'(goal), 32'h0);
    step(1);
    check("goal1", 32'(goal), 32'h1);
    check("lock_state", 32'(state), 32'h2);
    sensor = 1'b1; step(1);
    check("goal1_len", 32'(goal), 32'h0);
    check("score_g1", 32'({score1, score0}), 32'h01);
    sensor = 1'b0; step(1);
    sensor = 1'b1; step(1);
    sensor = 1'b0; step(1);
    check("lock_hold", 32'(state), 32'h2);
    step(1);
    check("lock_done", 32'(state), 32'h1);
    check("lock_nogoal", 32'(goal_cnt), 32'd1);
    check("lock_score", 32'({score1, score0}), 32'h01);

    sensor = 1'b1; step(1); sensor = 1'b0;
    step(2);
    check("goal2", 32'(goal), 32'h1);
    step(5);
    check("goal2_play", 32'(state), 32'h1);
    check("score_g2", 32'({score1, score0}), 32'h02);
    sensor = 1'b1; step(1); sensor = 1'b0;
    step(2);
    check("goal3", 32'(goal), 32'h1);
    step(2);
    check("win_state", 32'(state), 32'h3);
    check("win_over", 32'(match_over), 32'h1);
    check("score_g3", 32'({score1, score0}), 32'h03);
    sensor = 1'b1; step(1); sensor = 1'b0;
    step(5);
    check("over_ignore", 32'(goal_cnt), 32'd3);
    check("over_score", 32'({score1, score0}), 32'h03);
    check("over_hold", 32'(state), 32'h3);
    check("over_dis", 32'(dis_score), 32'h1);

    // OVER -> IDLE clears scores, then a second start plays again
    start = 1'b1; step(1); start = 1'b0;
    check("idle_state", 32'(state), 32'h0);
    check("idle_dis", 32'(dis_score), 32'h0);
    step(1);
    check("idle_score", 32'({score1, score0}), 32'h00);
    check("idle_time", 32'(time_left), 32'(TL_RST));
    start = 1'b1; step(1); start = 1'b0;
    check("replay_state", 32'(state), 32'h1);

    // two goals, then rst while locked out with score 2
    sensor = 1'b1; step(1); sensor = 1'b0;
    step(7);
    sensor = 1'b1; step(1); sensor = 1'b0;
    step(4);
    check("pre_rst_state", 32'(state), 32'h2);
    check("pre_rst_score", 32'({score1, score0}), 32'h02);
    rst = 1'b1; step(1);
    check("mrst_state", 32'(state), 32'h0);
    check("mrst_dis", 32'(dis_score), 32'h0);
    check("mrst_score", 32'({score1, score0}), 32'h00);
    check("mrst_time", 32'(time_left), 32'(TL_RST));
    check("mrst_goal", 32'(goal), 32'h0);
    rst = 1'b0;
    step(1);

    start = 1'b1; step(1); start = 1'b0;
`ifdef MATCH_TIMER_EN
    check("tmr_t0", 32'(time_left), 32'd3);
    step(9);
    check("tmr_t9", 32'(time_left), 32'd3);
    step(1);
    check("tmr_t10", 32'(time_left), 32'd2);
    step(10);
    check("tmr_t20", 32'(time_left), 32'd1);
    step(8);
    sensor = 1'b1; step(1); sensor = 1'b0;
    step(1);
    check("tmr_t30", 32'(time_left), 32'd0);
    check("tmr_t30_state", 32'(state), 32'h1);
    step(1);
    check("exp_goal", 32'(goal), 32'h1);
    check("exp_state", 32'(state), 32'h3);
    check("exp_over", 32'(match_over), 32'h1);
    step(1);
    check("exp_score", 32'({score1, score0}), 32'h01);
    check("exp_time", 32'(time_left), 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      step(10);
      check("notmr_time", 32'(time_left), 32'd0);
      check("notmr_state", 32'(state), 32'h1);
    end
    check("notmr_over", 32'(match_over), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000: clk cycles per match-timer second.
REQ-002 Parameter LOCKOUT_TICKS, default 50000000: cycles the sensor is ignored after a goal.
REQ-003 Parameter MATCH_SECS, default 90: match length in seconds (1..127).
REQ-004 Parameter WIN_SCORE, default 10: total score ending the match (1..99).
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 start  in  1  start/restart request; clean one-cycle pulse.
REQ-008 sensor  in  1  raw ball-sensor level, asynchronous to clk.
REQ-009 score0  in  4  BCD ones digit from the score counter.
REQ-010 score1  in  4  BCD tens digit from the score counter.
REQ-011 goal  out  1  one-cycle goal pulse to the score counter.
REQ-012 dis_score  out  1  score enable; 0 clears the score counter.
REQ-013 state  out  2  current state: IDLE=00, PLAY=01, LOCKOUT=10, OVER=11.
REQ-014 time_left  out  7  seconds remaining, binary.
REQ-015 match_over  out  1  high exactly while state==OVER.

Function
REQ-016 sensor passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized level.
REQ-017 goal asserts for exactly 1 cycle, 3 clk edges after sensor first samples high, only if state==PLAY when the edge is detected.
REQ-018 Edges in IDLE, LOCKOUT or OVER are dropped, not queued; sensor already high on entry to PLAY produces no goal.
REQ-019 dis_score = 0 in IDLE, 1 in PLAY, LOCKOUT and OVER.
REQ-020 IDLE -> PLAY on start; start ignored in PLAY and LOCKOUT.
REQ-021 PLAY -> LOCKOUT on the cycle goal is asserted; lockout counter loads LOCKOUT_TICKS-1.
REQ-022 LOCKOUT: counter decrements each cycle; at 0, -> PLAY next cycle (LOCKOUT_TICKS cycles total).
REQ-023 Win condition: score1*10 + score0 >= WIN_SCORE, evaluated in PLAY and LOCKOUT (score counter updates 1 cycle after goal).
REQ-024 Priority in PLAY/LOCKOUT: win > timer expiry > lockout done/goal; win or expiry -> OVER.
REQ-025 Goal coincident with expiry in PLAY: goal pulse still issued (last-second goal counts); next state OVER.
REQ-026 OVER holds scores (dis_score=1) indefinitely; start -> IDLE, clearing scores; a second start begins play.

Reset
REQ-027 On rst: state=IDLE, goal=0, dis_score=0, match_over=0, time_left=MATCH_SECS; synchronizer, edge register, lockout counter, prescaler = 0.
REQ-028 rst mid-match: next cycle IDLE; no goal pulse issued on or after the rst cycle; scores cleared via dis_score=0.
REQ-029 rst has priority over start, sensor and all transitions.

Configuration
REQ-030 Macro MATCH_TIMER_EN defined: prescaler counts 0..TICKS_PER_SEC-1 in PLAY/LOCKOUT; on wrap time_left decrements; expiry when time_left==0; time_left reloads to MATCH_SECS in IDLE; prescaler holds in IDLE/OVER.
REQ-031 Macro undefined: no prescaler/timer logic, time_left tied to 0, expiry never occurs; match ends only on win.

Verification (TICKS_PER_SEC=10, LOCKOUT_TICKS=5, MATCH_SECS=3, WIN_SCORE=3, score counter model attached)
REQ-032 rst, start, sensor 0->1 in PLAY -> goal high 1 cycle exactly 3 edges later, state=10 for 5 cycles, then 01; score0=1.
REQ-033 Sensor toggles 3 times during LOCKOUT -> no goal; score unchanged.
REQ-034 Three spaced goals -> score0=3, state=11, match_over=1 within 2 cycles of third goal; further sensor edges ignored.
REQ-035 MATCH_TIMER_EN, no goals -> time_left 3,2,1,0 at 10-cycle steps, OVER on expiry; goal in the expiry cycle -> pulse issued, score increments, state=11.
REQ-036 rst asserted in LOCKOUT with score 2 -> next cycle state=00, dis_score=0, score 00, time_left=3, no goal.
REQ-037 OVER, start -> IDLE, scores 00; start -> PLAY; macro undefined build -> time_left constant 0, match never times out.
